// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - shared CPU types: word, opcode and fetch FSM state
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [5:0] {
    RTYPE = 6'b000000,
    J     = 6'b000010,
    JAL   = 6'b000011,
    BEQ   = 6'b000100,
    BNE   = 6'b000101,
    ADDI  = 6'b001000,
    HALT  = 6'b111111
  } opcode_t;

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    PEND   = 2'd1,
    HALTED = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetch_if.sv
// rtl/fetch_if.sv - signal bundle between fetch, imem port, hazard unit and decode
interface fetch_if
  import cpu_types_pkg::*;
(
  input logic CLK
);
  logic  RST;
  logic  ihit;
  word_t iload;
  logic  hazard;
  logic  branch;
  logic  jump;
  word_t branch_target;
  word_t jump_target;
  logic  imemREN;
  word_t imemaddr;
  word_t if_instr;
  word_t if_npc;
  logic  if_valid;
  logic  halted;

  modport fetch (
    input  CLK, RST, ihit, iload, hazard, branch, jump, branch_target, jump_target,
    output imemREN, imemaddr, if_instr, if_npc, if_valid, halted
  );

  modport env (
    input  CLK, imemREN, imemaddr, if_instr, if_npc, if_valid, halted,
    output RST, ihit, iload, hazard, branch, jump, branch_target, jump_target
  );
endinterface

// File: rtl/if_id_reg.sv
// rtl/if_id_reg.sv - IF/ID pipeline latch; flush wins over load, otherwise holds
module if_id_reg
  import cpu_types_pkg::*;
(
  input  logic  CLK,
  input  logic  RST,
  input  logic  load,
  input  logic  flush,
  input  word_t instr_in,
  input  word_t npc_in,
  output word_t instr,
  output word_t npc,
  output logic  valid
);

  word_t instr_q, instr_d;
  word_t npc_q, npc_d;
  logic  valid_q, valid_d;

  always_comb begin
    instr_d = instr_q;
    npc_d   = npc_q;
    valid_d = valid_q;
    if (flush) begin
      instr_d = '0;
      npc_d   = '0;
      valid_d = 1'b0;
    end else if (load) begin
      instr_d = instr_in;
      npc_d   = npc_in;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      instr_q <= '0;
      npc_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      instr_q <= instr_d;
      npc_q   <= npc_d;
      valid_q <= valid_d;
    end
  end

  assign instr = instr_q;
  assign npc   = npc_q;
  assign valid = valid_q;

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - IF stage: owns the PC, drives imem requests, loads IF/ID
module fetch_unit
  import cpu_types_pkg::*;
#(
  parameter word_t PC_INIT = 32'h0
) (
  input  logic  CLK,
  input  logic  RST,
  input  logic  ihit,
  input  word_t iload,
  input  logic  hazard,
  input  logic  branch,
  input  logic  jump,
  input  word_t branch_target,
  input  word_t jump_target,
  output logic  imemREN,
  output word_t imemaddr,
  output word_t if_instr,
  output word_t if_npc,
  output logic  if_valid,
  output logic  halted
);

  fetch_state_t state_q, state_d;
  word_t        pc_q, pc_d;
  word_t        pend_pc_q, pend_pc_d;
  logic         ifid_load, ifid_flush;
  word_t        pc_plus4;
  word_t        target;
  logic         redirect;
  logic         halt_seen;

  assign pc_plus4  = pc_q + 32'd4;
  assign target    = jump ? jump_target : branch_target;
  assign redirect  = (branch | jump) & ~hazard & (state_q == FETCH);
  assign halt_seen = if_valid & (if_instr[31:26] == HALT) & ~hazard;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    pend_pc_d  = pend_pc_q;
    ifid_load  = 1'b0;
    ifid_flush = 1'b0;
    unique case (state_q)
      FETCH: begin
        if (halt_seen) begin
          state_d = HALTED;
        end else if (redirect) begin
          ifid_flush = 1'b1;
          if (ihit) begin
            pc_d = target;
          end else begin
            // Keep imemaddr stable until the outstanding fetch returns.
            pend_pc_d = target;
            state_d   = PEND;
          end
        end else if (!hazard) begin
          if (ihit) begin
            pc_d      = pc_plus4;
            ifid_load = 1'b1;
          end else begin
            ifid_flush = 1'b1;
          end
        end
      end
      PEND: begin
        ifid_flush = 1'b1;
        if (ihit) begin
          pc_d    = pend_pc_q;
          state_d = FETCH;
        end
      end
      HALTED: begin
        state_d = HALTED;
      end
      default: begin
        state_d = FETCH;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= FETCH;
      pc_q      <= PC_INIT;
      pend_pc_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      pend_pc_q <= pend_pc_d;
    end
  end

  if_id_reg u_if_id (
    .CLK      (CLK),
    .RST      (RST),
    .load     (ifid_load),
    .flush    (ifid_flush),
    .instr_in (iload),
    .npc_in   (pc_plus4),
    .instr    (if_instr),
    .npc      (if_npc),
    .valid    (if_valid)
  );

  assign imemREN  = (state_q != HALTED);
  assign imemaddr = pc_q;
  assign halted   = (state_q == HALTED);

endmodule
